// File: rtl/synth_pkg.sv
// Types and helpers shared by the voice allocator and its LRU age tracker.
package synth_pkg;

  localparam int NOTE_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ISSUE  = 2'd2
  } alloc_state_t;

  typedef struct packed {
    logic                  on;
    logic [NOTE_W_DEF-1:0] note;
  } note_event_t;

  function automatic int voice_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lru_age_tracker.sv
// Per-voice LRU ages (0 = most recently started, NUM_VOICES-1 = oldest), kept as
// a permutation; reports the oldest voice among a qualifying mask.
module lru_age_tracker
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = voice_idx_w(NUM_VOICES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  touch_i,
  input  logic [IDX_W-1:0]      touch_idx_i,
  input  logic [NUM_VOICES-1:0] mask_i,
  output logic [IDX_W-1:0]      oldest_idx_o,
  output logic                  oldest_valid_o
);

  logic [IDX_W-1:0] age_q [NUM_VOICES];
  logic [IDX_W-1:0] age_d [NUM_VOICES];
  logic [IDX_W-1:0] best;

  // Touched voice becomes youngest; everyone younger than it ages by one.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_d[i] = age_q[i];
      if (touch_i) begin
        if (IDX_W'(i) == touch_idx_i) age_d[i] = '0;
        else if (age_q[i] < age_q[touch_idx_i]) age_d[i] = age_q[i] + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= IDX_W'(i);
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    oldest_idx_o   = '0;
    oldest_valid_o = 1'b0;
    best           = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (mask_i[i] && (!oldest_valid_o || age_q[i] > best)) begin
        oldest_valid_o = 1'b1;
        best           = age_q[i];
        oldest_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, one-cycle start pulses out.
// Build option VOICE_STEAL_EN enables stealing (oldest released, then oldest overall).
//   state  | meaning
//   IDLE   | ready for an event
//   LOOKUP | choose target voice from registered state
//   ISSUE  | pulse start / update held, note, pending, ages
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = NOTE_W_DEF  // note_event_t is sized by NOTE_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         ev_valid_i,
  output logic                         ev_ready_o,
  input  logic                         ev_on_i,
  input  logic [NOTE_W-1:0]            ev_note_i,
  input  logic [NUM_VOICES-1:0]        voice_idle_i,
  output logic [NUM_VOICES-1:0]        voice_start_o,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note_o,
  output logic [NUM_VOICES-1:0]        voice_held_o,
  output logic                         note_dropped_o
);

  localparam int IDX_W = voice_idx_w(NUM_VOICES);

  alloc_state_t          state_q, state_d;
  note_event_t           ev_q, ev_d;
  logic [IDX_W-1:0]      tgt_q, sel_idx;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] held_q, held_d, pend_q, pend_d;
  logic                  drop_q, drop_d;
  logic [NUM_VOICES-1:0] match_v, free_v, lru_mask;
  logic                  match_any, free_any, tgt_found;
  logic [IDX_W-1:0]      match_idx, free_idx, lru_idx;
  logic                  lru_valid;
  logic                  accept, issue_on, issue_off;

  assign accept    = ev_valid_i && (state_q == IDLE);
  assign issue_on  = (state_q == ISSUE) && ev_q.on;
  assign issue_off = (state_q == ISSUE) && !ev_q.on;
  assign lru_mask  = (|(~held_q)) ? ~held_q : '1;

  lru_age_tracker #(
    .NUM_VOICES(NUM_VOICES),
    .IDX_W     (IDX_W)
  ) u_lru (
    .clk_i         (clk_i),
    .rst_i         (reset_i),
    .touch_i       (issue_on),
    .touch_idx_i   (tgt_q),
    .mask_i        (lru_mask),
    .oldest_idx_o  (lru_idx),
    .oldest_valid_o(lru_valid)
  );

  // Descending scan so the lowest index wins.
  always_comb begin
    match_v   = '0;
    free_v    = '0;
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      match_v[i] = held_q[i] && (note_q[i] == ev_q.note);
      free_v[i]  = !held_q[i] && !pend_q[i] && voice_idle_i[i];
      if (match_v[i]) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (free_v[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    tgt_found = 1'b0;
    sel_idx   = '0;
    if (!ev_q.on || match_any) begin
      tgt_found = match_any;
      sel_idx   = match_idx;
    end else if (free_any) begin
      tgt_found = 1'b1;
      sel_idx   = free_idx;
    end
`ifdef VOICE_STEAL_EN
    else begin
      tgt_found = lru_valid;
      sel_idx   = lru_idx;
    end
`endif
  end

`ifdef VOICE_STEAL_EN
  assign drop_d = 1'b0;
`else
  logic unused_lru;
  assign unused_lru = ^{lru_idx, lru_valid};
  assign drop_d     = (state_q == LOOKUP) && ev_q.on && !tgt_found;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = tgt_found ? ISSUE : IDLE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_ready_o    = (state_q == IDLE);
    voice_start_o = '0;
    if (issue_on) voice_start_o[tgt_q] = 1'b1;
  end

  // Pending bridges the cycle(s) before the envelope drops its idle flag.
  always_comb begin
    ev_d      = ev_q;
    held_d    = held_q;
    pend_d    = pend_q & voice_idle_i;
    if (accept) begin
      ev_d.on   = ev_on_i;
      ev_d.note = ev_note_i;
    end
    if (issue_on) begin
      held_d[tgt_q] = 1'b1;
      pend_d[tgt_q] = 1'b1;
    end
    if (issue_off) held_d[tgt_q] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ev_q   <= '0;
      tgt_q  <= '0;
      held_q <= '0;
      pend_q <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= '0;
    end else begin
      ev_q   <= ev_d;
      held_q <= held_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      if (state_q == LOOKUP) tgt_q <= sel_idx;
      if (issue_on) note_q[tgt_q] <= ev_q.note;
    end
  end

  always_comb begin
    voice_note_o = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_note_o[i*NOTE_W +: NOTE_W] = note_q[i];
  end

  assign voice_held_o   = held_q;
  assign note_dropped_o = drop_q;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler sitting between the note-event source (MIDI/PS register interface) and NUM_VOICES parallel ADSR envelope generators.
- Accepts note-on/note-off events over a valid/ready handshake.
- Picks a target voice and issues a one-cycle start pulse to that voice's envelope generator.
- Tracks per-voice note number, key-held state and least-recently-used age for voice reuse.

Parameters:
NUM_VOICES, 4, number of envelope/oscillator voices (power of 2, 2..16)
NOTE_W, 7, note number width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ev_valid  in  1  note event present
ev_ready  out  1  allocator can accept an event
ev_on  in  1  1 = note-on, 0 = note-off
ev_note  in  NOTE_W  note number
voice_idle  in  NUM_VOICES  per-voice envelope idle flag from each envelope generator
voice_start  out  NUM_VOICES  one-cycle start pulse per voice
voice_note  out  NUM_VOICES*NOTE_W  latched note per voice; voice i at [i*NOTE_W +: NOTE_W]
voice_held  out  NUM_VOICES  key currently held on voice
note_dropped  out  1  one-cycle pulse: note-on discarded (only without steal feature)

Behaviour:
- Reset: state IDLE; ev_ready=1; voice_start=0; voice_note=0; voice_held=0; pending=0; note_dropped=0.
- Voice ages initialise to age[i]=i, so voice NUM_VOICES-1 is oldest.
- FSM states and transitions:
  - IDLE: ev_ready=1. Event is accepted when ev_valid&ev_ready; register {ev_on, ev_note}; go to LOOKUP.
  - LOOKUP: ev_ready=0. Compute the target voice from registered state and register it; go to ISSUE. Go to IDLE instead when there is no target (note-off with no match, or dropped note-on).
  - ISSUE: ev_ready=0. Apply the action; go to IDLE.
- Latency: handshake in cycle T -> voice_start pulse in cycle T+2. Next event can be accepted in cycle T+3 (max one event per 3 cycles).
- Voice free iff !held[i] && !pending[i] && voice_idle[i].
- pending[i]:
  - Set in ISSUE for a note-on to voice i.
  - Cleared on the first cycle voice_idle[i]==0 (covers the 1-cycle lag before the envelope leaves idle).
  - A retriggered voice already non-idle clears pending on the next cycle.
- Note-on target priority, evaluated in LOOKUP:
  1. A voice with held && voice_note==ev_note: retrigger that same voice, no duplicate.
  2. The lowest-index free voice.
  3. The oldest voice with !held.
  4. The oldest voice overall (steal).
- Note-on in ISSUE:
  - voice_start[t]=1, voice_note[t]=ev_note, held[t]=1, pending[t]=1.
  - Age update: age[t]=0; every voice with age < old age[t] increments by 1. Ages stay a permutation of 0..NUM_VOICES-1.
- Note-off:
  - Target is the lowest-index voice with held && voice_note==ev_note. In ISSUE, held[t]=0; no start pulse; ages unchanged.
  - No match: ignored silently, return to IDLE from LOOKUP.
- voice_note holds its value after release; it is not cleared.
- Envelope completing (voice_idle rises) while held=1: the voice stays allocated until note-off.
- voice_start is one-hot or zero, never multi-bit.
- Reset mid-operation: the in-flight event is discarded and all tracking state returns to reset values.

Optional Feature:
VOICE_STEAL_EN
- Defined: priorities 3 and 4 apply; note_dropped is tied to 0.
- Undefined: only priorities 1 and 2 apply. With no match and no free voice, the note-on is discarded: note_dropped pulses in the cycle after LOOKUP, and the FSM returns to IDLE without ISSUE.

Decomposition:
- synth_pkg holds:
  - alloc_state_t enum {IDLE, LOOKUP, ISSUE}
  - note_event_t packed struct {on, note}
  - VOICE_IDX_W = $clog2(NUM_VOICES) helper function
  - NOTE_W default constant
- One sub-module, lru_age_tracker: holds the age array and the touch(t) update, and outputs an oldest-index search over a qualifying mask.

Test Plan:
1. After reset, all voice_idle=1; note-on 60 handshake at T -> voice_start=0001 at T+2; voice_note[0]=60; held=0001; ev_ready low for T+1..T+2.
2. Note-ons 60, 62, 64, 65 back-to-back with idle envelopes, whose voice_idle drops 1 cycle after each start -> voices 0, 1, 2, 3 assigned in order, with no double allocation despite the idle lag.
3. All 4 held; note-on 67 -> with VOICE_STEAL_EN, voice 0 (oldest) gets start and note 67. Without VOICE_STEAL_EN, note_dropped pulses once, no voice_start, and voice_note is unchanged.
4. Note-off 62 releases voice 1 (voice_idle stays 0); then note-on 69 with all others held -> voice 1 chosen via the oldest-non-held rule.
5. Note-on 60 while 60 is held on voice 2 -> voice_start=0100 (retrigger), no other voice touched.
6. Note-off 50 with no match -> no state change, ev_ready high again at T+2. Assert reset during LOOKUP -> voice_held=0, no voice_start pulse, ev_ready=1.
